universal_shift_register: RTL

//  Parametrised multi-mode shift register: load, logical/arithmetic shift, rotate, clear.

---
 rtl/usr_pkg.sv | 22 ++
 rtl/usr_shift_step.sv | 39 +++
 rtl/universal_shift_register.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/usr_pkg.sv
// Shared op-codes, FSM state encoding and a decode helper for universal_shift_register.
package usr_pkg;

  localparam logic [2:0] USR_OP_NOP  = 3'b000;
  localparam logic [2:0] USR_OP_LOAD = 3'b001;
  localparam logic [2:0] USR_OP_SHL  = 3'b010;
  localparam logic [2:0] USR_OP_SHR  = 3'b011;
  localparam logic [2:0] USR_OP_ROL  = 3'b100;
  localparam logic [2:0] USR_OP_ROR  = 3'b101;
  localparam logic [2:0] USR_OP_ASR  = 3'b110;
  localparam logic [2:0] USR_OP_CLR  = 3'b111;

  typedef enum logic {
    USR_IDLE,
    USR_SHIFT
  } usr_state_t;

  function automatic logic usr_is_shift(input logic [2:0] op);
    return (op != USR_OP_NOP) && (op != USR_OP_LOAD) && (op != USR_OP_CLR);
  endfunction

endpackage

// File: rtl/usr_shift_step.sv
// Combinational single-step shift/rotate unit: one bit of movement per use,
// reporting the bit that leaves the register.
module usr_shift_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  input  logic [2:0]       op,
  input  logic             fill,
  output logic [WIDTH-1:0] next_value,
  output logic             out_bit
);

  always_comb begin
    next_value = value;
    out_bit    = 1'b0;
    case (op)
      USR_OP_SHL: begin
        next_value = {value[WIDTH-2:0], fill};
        out_bit    = value[WIDTH-1];
      end
      USR_OP_ROL: begin
        next_value = {value[WIDTH-2:0], value[WIDTH-1]};
        out_bit    = value[WIDTH-1];
      end
      USR_OP_SHR, USR_OP_ASR: begin
        next_value = {fill, value[WIDTH-1:1]};
        out_bit    = value[0];
      end
      USR_OP_ROR: begin
        next_value = {value[0], value[WIDTH-1:1]};
        out_bit    = value[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/universal_shift_register.sv
// Multi-mode shift register with start/busy/done handshake. Serial engine (one step
// per cycle) by default; define USR_BARREL_EN for the single-cycle barrel path.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] load_data,
  input  logic             serial_in,
  output logic [WIDTH-1:0] out,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] out_d, out_q;
  logic             sout_d, sout_q;
  logic             done_d, done_q;
  logic             fill_now;

  // ASR sign comes from the register as it stood when the command was accepted.
  assign fill_now = ((op == USR_OP_SHL) || (op == USR_OP_SHR)) ? serial_in : out_q[WIDTH-1];

`ifdef USR_BARREL_EN
  localparam int NSTEP = 2**AMT_W - 1;

  logic [WIDTH-1:0] chain_val [0:NSTEP];
  logic             chain_bit [0:NSTEP];

  // Tap 0 is the untouched register so amount==0 leaves out/serial_out unchanged.
  assign chain_val[0] = out_q;
  assign chain_bit[0] = sout_q;

  for (genvar k = 1; k <= NSTEP; k++) begin : g_chain
    usr_shift_step #(.WIDTH(WIDTH)) u_step (
      .value      (chain_val[k-1]),
      .op         (op),
      .fill       (fill_now),
      .next_value (chain_val[k]),
      .out_bit    (chain_bit[k])
    );
  end

  always_comb begin
    out_d  = out_q;
    sout_d = sout_q;
    done_d = 1'b0;
    if (start) begin
      done_d = 1'b1;
      if (usr_is_shift(op)) begin
        out_d  = chain_val[amount];
        sout_d = chain_bit[amount];
      end else if (op == USR_OP_LOAD) begin
        out_d = load_data;
      end else if (op == USR_OP_CLR) begin
        out_d = '0;
      end
    end
  end

  assign busy = 1'b0;
`else
  usr_state_t       state_d, state_q;
  logic [2:0]       op_d, op_q;
  logic             fill_d, fill_q;
  logic [AMT_W-1:0] cnt_d, cnt_q;
  logic [2:0]       step_op;
  logic             step_fill;
  logic [WIDTH-1:0] step_val;
  logic             step_bit;

  // The first step runs at the accepting edge straight from the ports.
  assign step_op   = (state_q == USR_SHIFT) ? op_q   : op;
  assign step_fill = (state_q == USR_SHIFT) ? fill_q : fill_now;

  usr_shift_step #(.WIDTH(WIDTH)) u_step (
    .value      (out_q),
    .op         (step_op),
    .fill       (step_fill),
    .next_value (step_val),
    .out_bit    (step_bit)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    sout_d  = sout_q;
    done_d  = 1'b0;
    case (state_q)
      USR_IDLE: begin
        if (start) begin
          if (usr_is_shift(op) && (amount != '0)) begin
            out_d  = step_val;
            sout_d = step_bit;
            if (amount == AMT_W'(1)) begin
              done_d = 1'b1;
            end else begin
              state_d = USR_SHIFT;
              op_d    = op;
              fill_d  = fill_now;
              cnt_d   = amount - AMT_W'(1);
            end
          end else begin
            done_d = 1'b1;
            if (op == USR_OP_LOAD) begin
              out_d = load_data;
            end else if (op == USR_OP_CLR) begin
              out_d = '0;
            end
          end
        end
      end
      USR_SHIFT: begin
        out_d  = step_val;
        sout_d = step_bit;
        cnt_d  = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          done_d  = 1'b1;
          state_d = USR_IDLE;
        end
      end
      default: state_d = USR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= USR_IDLE;
      op_q    <= USR_OP_NOP;
      fill_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == USR_SHIFT);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q  <= '0;
      sout_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      sout_q <= sout_d;
      done_q <= done_d;
    end
  end

  assign out        = out_q;
  assign serial_out = sout_q;
  assign done       = done_q;

endmodule
